// File: rtl/ms_pkg.sv
// ms_pkg: shared definitions for the minesweeper controller.
//   state_t : 4-bit FSM state encodings (also exported on the cs debug port)
//   dir_t   : latched cursor direction codes
//   WL_*    : win/lose status codes driven on wl
//   idx_w() : bit width needed to index n items
package ms_pkg;

   typedef enum logic [3:0] {
      S_INIT     = 4'd0,
      S_SET_BOMB = 4'd1,
      S_GAME     = 4'd2,
      S_MOVE     = 4'd3,
      S_MOVE_SET = 4'd4,
      S_REVEAL   = 4'd5,
      S_FLAG     = 4'd6,
      S_WIN      = 4'd7,
      S_LOSE     = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      DIR_R = 2'b00,
      DIR_U = 2'b01,
      DIR_L = 2'b10,
      DIR_D = 2'b11
   } dir_t;

   localparam logic [1:0] WL_PLAY = 2'b00;
   localparam logic [1:0] WL_WIN  = 2'b01;
   localparam logic [1:0] WL_LOSE = 2'b10;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ms_lfsr16.sv
// ms_lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Ports:
//   clock : system clock
//   reset : synchronous, active-low; loads SEED
//   q     : current LFSR state, advances every cycle out of reset
module ms_lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] q
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         q <= SEED;
      end else begin
         q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
      end
   end

endmodule

// File: rtl/minesweeper_ctrl.sv
// minesweeper_ctrl: W x H minesweeper game controller.
// Places mines (LFSR-random or fixed pattern), moves a cursor, reveals and
// flags cells, and reports win/lose.
// Ports:
//   clock, reset                   : clock; synchronous active-low reset
//   restart                        : start a new game (level)
//   confirm / flag                 : reveal / toggle flag under cursor (level)
//   readkey, udlr[3:0]             : direction key held, one-hot {up,down,left,right}
//   wl[1:0]                        : 00 playing, 01 win, 10 lose
//   bomb/reveal/flag/cursor_grid   : per-cell maps, bit = row*GRID_W+col
//   d_enable                       : one-cycle pulse when the display must refresh
//   cs[3:0]                        : current FSM state
module minesweeper_ctrl
   import ms_pkg::*;
#(
   parameter int                       GRID_W        = 3,
   parameter int                       GRID_H        = 3,
   parameter int                       NUM_BOMBS     = 2,
   parameter logic [15:0]              LFSR_SEED     = 16'hACE1,
   parameter bit                       FIXED_MAP     = 1'b0,
   parameter logic [GRID_W*GRID_H-1:0] FIXED_PATTERN = 9'h180
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     restart,
   input  logic                     confirm,
   input  logic                     flag,
   input  logic                     readkey,
   input  logic [3:0]               udlr,
   output logic [1:0]               wl,
   output logic [GRID_W*GRID_H-1:0] bomb_grid,
   output logic [GRID_W*GRID_H-1:0] reveal_grid,
   output logic [GRID_W*GRID_H-1:0] flag_grid,
   output logic [GRID_W*GRID_H-1:0] cursor_grid,
   output logic                     d_enable,
   output logic [3:0]               cs
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int IW    = idx_w(CELLS);
   localparam int CW    = 4;
   localparam logic [CELLS-1:0] ONE_HOT0 = {{(CELLS-1){1'b0}}, 1'b1};

   state_t          state_reg;
   logic [CW-1:0]   row_reg;
   logic [CW-1:0]   col_reg;
   logic [IW-1:0]   remaining_reg;
   dir_t            dir_reg;
   logic            move_ok_reg;
   logic            first_reg;      // first cycle of S_REVEAL / S_FLAG
   logic            flag_hold_reg;  // flag seen during a reveal; ignore until released

   logic [15:0]     lfsr;
   logic            unused_lfsr_hi;
   logic [7:0]      pick;
   logic [255:0]    bomb_pad;
   logic            pick_ok;
   logic [CELLS-1:0] pick_mask;
   logic [IW-1:0]   cur_idx;
   dir_t            dir_dec;
   logic            dir_valid;

   ms_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clock (clock),
      .reset (reset),
      .q     (lfsr)
   );

   assign pick           = lfsr[7:0];
   assign unused_lfsr_hi = ^lfsr[15:8];
   // Zero-extended copy so any 8-bit pick can be looked up safely.
   assign bomb_pad       = 256'(bomb_grid);
   assign pick_ok        = (int'(pick) < CELLS) && !bomb_pad[pick];
   assign pick_mask      = ONE_HOT0 << pick;

   assign cur_idx     = IW'(int'(row_reg) * GRID_W + int'(col_reg));
   assign cursor_grid = ONE_HOT0 << cur_idx;
   assign cs          = state_reg;

   // Anything other than exactly one key bit means "no move".
   always_comb begin
      dir_dec   = DIR_R;
      dir_valid = 1'b1;
      case (udlr)
         4'b1000: dir_dec = DIR_U;
         4'b0100: dir_dec = DIR_D;
         4'b0010: dir_dec = DIR_L;
         4'b0001: dir_dec = DIR_R;
         default: dir_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg     <= S_INIT;
         bomb_grid     <= '0;
         reveal_grid   <= '0;
         flag_grid     <= '0;
         wl            <= WL_PLAY;
         d_enable      <= 1'b0;
         row_reg       <= '0;
         col_reg       <= '0;
         remaining_reg <= '0;
         dir_reg       <= DIR_R;
         move_ok_reg   <= 1'b0;
         first_reg     <= 1'b0;
         flag_hold_reg <= 1'b0;
      end else begin
         d_enable <= 1'b0;
         if (!flag) flag_hold_reg <= 1'b0;

         if (restart && state_reg != S_INIT) begin
            // Clear immediately so the abandoned game never shows in S_INIT.
            state_reg   <= S_INIT;
            bomb_grid   <= '0;
            reveal_grid <= '0;
            flag_grid   <= '0;
            wl          <= WL_PLAY;
            row_reg     <= '0;
            col_reg     <= '0;
         end else begin
            case (state_reg)
               S_INIT: begin
                  bomb_grid     <= '0;
                  reveal_grid   <= '0;
                  flag_grid     <= '0;
                  wl            <= WL_PLAY;
                  row_reg       <= '0;
                  col_reg       <= '0;
                  remaining_reg <= IW'(NUM_BOMBS);
                  if (!restart) state_reg <= S_SET_BOMB;
               end
               S_SET_BOMB: begin
                  if (FIXED_MAP) begin
                     bomb_grid <= FIXED_PATTERN;
                     d_enable  <= 1'b1;
                     state_reg <= S_GAME;
                  end else if (pick_ok) begin
                     bomb_grid     <= bomb_grid | pick_mask;
                     remaining_reg <= remaining_reg - IW'(1);
                     // Leave as the last mine lands so the pulse shows the full map.
                     if (remaining_reg == IW'(1)) begin
                        d_enable  <= 1'b1;
                        state_reg <= S_GAME;
                     end
                  end
               end
               S_GAME: begin
                  if (|(bomb_grid & reveal_grid))      wl <= WL_LOSE;
                  else if (&(reveal_grid | bomb_grid)) wl <= WL_WIN;

                  if (wl == WL_WIN)                     state_reg <= S_WIN;
                  else if (wl == WL_LOSE)               state_reg <= S_LOSE;
                  else if (confirm) begin
                     state_reg <= S_REVEAL;
                     first_reg <= 1'b1;
                  end else if (flag && !flag_hold_reg) begin
                     state_reg <= S_FLAG;
                     first_reg <= 1'b1;
                  end else if (readkey) begin
                     state_reg   <= S_MOVE;
                     dir_reg     <= dir_dec;
                     move_ok_reg <= dir_valid;
                  end
               end
               S_MOVE: begin
                  if (readkey) begin
                     dir_reg     <= dir_dec;
                     move_ok_reg <= dir_valid;
                  end else begin
                     state_reg <= S_MOVE_SET;
                  end
               end
               S_MOVE_SET: begin
                  if (move_ok_reg) begin
                     case (dir_reg)
                        DIR_R: if (col_reg != CW'(GRID_W - 1)) col_reg <= col_reg + CW'(1);
                        DIR_L: if (col_reg != '0)              col_reg <= col_reg - CW'(1);
                        DIR_U: if (row_reg != '0)              row_reg <= row_reg - CW'(1);
                        DIR_D: if (row_reg != CW'(GRID_H - 1)) row_reg <= row_reg + CW'(1);
                     endcase
                  end
                  d_enable  <= 1'b1;
                  state_reg <= S_GAME;
               end
               S_REVEAL: begin
                  if (first_reg) begin
                     first_reg <= 1'b0;
                     if (!flag_grid[cur_idx] && !reveal_grid[cur_idx]) begin
                        reveal_grid[cur_idx] <= 1'b1;
                        d_enable             <= 1'b1;
                     end
                  end
                  if (flag) flag_hold_reg <= 1'b1;
                  if (!confirm) state_reg <= S_GAME;
               end
               S_FLAG: begin
                  if (first_reg) begin
                     first_reg <= 1'b0;
                     if (!reveal_grid[cur_idx]) begin
                        flag_grid[cur_idx] <= ~flag_grid[cur_idx];
                        d_enable           <= 1'b1;
                     end
                  end
                  if (!flag) state_reg <= S_GAME;
               end
               S_WIN, S_LOSE: begin
                  state_reg <= state_reg;
               end
               default: state_reg <= S_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// tb_minesweeper_ctrl: scoreboard bench. Instance A uses the fixed 3x3 map
// (cells 7 and 8 mined); instance B uses random placement. A game model
// predicts each display refresh; a monitor pops and compares on d_enable.
`timescale 1ns/1ps
module tb_minesweeper_ctrl;
   import ms_pkg::*;

   localparam int W = 3;
   localparam int H = 3;
   localparam int N = W * H;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // instance A (fixed map)
   logic restart = 1'b0, confirm = 1'b0, flag = 1'b0, readkey = 1'b0;
   logic [3:0] udlr = 4'b0;
   logic [1:0] wl;
   logic [N-1:0] bomb_grid, reveal_grid, flag_grid, cursor_grid;
   logic d_enable;
   logic [3:0] cs;

   // instance B (random map)
   logic restart_b = 1'b0;
   logic idle_in = 1'b0;
   logic [3:0] idle_udlr = 4'b0;
   logic [1:0] wl_b;
   logic [N-1:0] bomb_b, reveal_b, flag_b, cursor_b;
   logic d_enable_b;
   logic [3:0] cs_b;

   minesweeper_ctrl #(.GRID_W(W), .GRID_H(H), .NUM_BOMBS(2), .LFSR_SEED(16'hACE1),
                      .FIXED_MAP(1'b1), .FIXED_PATTERN(9'h180)) dut_a (
      .clock(clock), .reset(reset), .restart(restart), .confirm(confirm), .flag(flag),
      .readkey(readkey), .udlr(udlr), .wl(wl), .bomb_grid(bomb_grid),
      .reveal_grid(reveal_grid), .flag_grid(flag_grid), .cursor_grid(cursor_grid),
      .d_enable(d_enable), .cs(cs));

   minesweeper_ctrl #(.GRID_W(W), .GRID_H(H), .NUM_BOMBS(2), .LFSR_SEED(16'hACE1),
                      .FIXED_MAP(1'b0), .FIXED_PATTERN(9'h180)) dut_b (
      .clock(clock), .reset(reset), .restart(restart_b), .confirm(idle_in), .flag(idle_in),
      .readkey(idle_in), .udlr(idle_udlr), .wl(wl_b), .bomb_grid(bomb_b),
      .reveal_grid(reveal_b), .flag_grid(flag_b), .cursor_grid(cursor_b),
      .d_enable(d_enable_b), .cs(cs_b));

   int checks = 0;
   int passed = 0;

   // game model
   logic [N-1:0] m_bomb, m_rev, m_flag;
   int           m_row, m_col;
   logic [1:0]   m_wl;
   logic [4*N-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s got=%0h want=%0h", name, got, want);
   endtask

   function automatic logic [N-1:0] m_cursor();
      logic [N-1:0] one;
      one = 1;
      return one << (m_row * W + m_col);
   endfunction

   function automatic logic [4*N-1:0] dut_snap();
      return {bomb_grid, reveal_grid, flag_grid, cursor_grid};
   endfunction

   task automatic push_snap();
      exp_q.push_back({m_bomb, m_rev, m_flag, m_cursor()});
   endtask

   task automatic model_new_game();
      m_bomb = 9'h180; m_rev = '0; m_flag = '0;
      m_row = 0; m_col = 0; m_wl = WL_PLAY;
      push_snap();
   endtask

   // d: 0 up, 1 down, 2 left, 3 right
   task automatic model_move(input int d);
      if (m_wl != WL_PLAY) return;
      case (d)
         0: if (m_row > 0)     m_row--;
         1: if (m_row < H - 1) m_row++;
         2: if (m_col > 0)     m_col--;
         default: if (m_col < W - 1) m_col++;
      endcase
      push_snap();
   endtask

   task automatic model_reveal();
      int i;
      if (m_wl != WL_PLAY) return;
      i = m_row * W + m_col;
      if (m_flag[i] || m_rev[i]) return;
      m_rev[i] = 1'b1;
      push_snap();
      if (m_bomb[i])                 m_wl = WL_LOSE;
      else if ((m_rev | m_bomb) == '1) m_wl = WL_WIN;
   endtask

   task automatic model_flag();
      int i;
      if (m_wl != WL_PLAY) return;
      i = m_row * W + m_col;
      if (m_rev[i]) return;
      m_flag[i] = ~m_flag[i];
      push_snap();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic settle(input string name);
      check({name, "_pending_pulses"}, 64'(exp_q.size()), 64'd0);
      check({name, "_wl"}, 64'(wl), 64'(m_wl));
   endtask

   task automatic do_move(input int d);
      model_move(d);
      udlr = 4'b1000 >> d;
      readkey = 1'b1;
      tick($urandom_range(1, 4));
      readkey = 1'b0;
      udlr = 4'b0;
      tick(5);
      settle("move");
   endtask

   task automatic do_reveal();
      model_reveal();
      confirm = 1'b1;
      tick($urandom_range(1, 4));
      confirm = 1'b0;
      tick(5);
      settle("reveal");
   endtask

   task automatic do_flag();
      model_flag();
      flag = 1'b1;
      tick($urandom_range(1, 4));
      flag = 1'b0;
      tick(5);
      settle("flag");
   endtask

   task automatic goto_cell(input int r, input int c);
      int guard = 0;
      while ((m_row != r || m_col != c) && guard < 8) begin
         if (m_row < r)      do_move(1);
         else if (m_row > r) do_move(0);
         else if (m_col < c) do_move(3);
         else                do_move(2);
         guard++;
      end
   endtask

   task automatic check_cleared(input string name);
      check({name, "_cs"}, 64'(cs), 64'(S_INIT));
      check({name, "_grids"}, 64'({bomb_grid, reveal_grid, flag_grid}), 64'd0);
      check({name, "_cursor"}, 64'(cursor_grid), 64'h001);
      check({name, "_wl"}, 64'(wl), 64'(WL_PLAY));
   endtask

   task automatic do_restart();
      restart = 1'b1;
      tick(2);
      check_cleared("restart");
      model_new_game();
      restart = 1'b0;
      tick(4);
      settle("restart");
   endtask

   task automatic monitor();
      logic [4*N-1:0] e;
      forever begin
         @(negedge clock);
         if (d_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_pulse got=%0h want=no_pulse", dut_snap());
            end else begin
               e = exp_q.pop_front();
               check("pulse_snapshot", 64'(dut_snap()), 64'(e));
            end
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] maps[20];
      int n;
      int r;
      logic differ;

      fork
         monitor();
      join_none

      // 1: reset and fixed-map start
      tick(2);
      check("reset_cs", 64'(cs), 64'(S_INIT));
      check("reset_grids", 64'({bomb_grid, reveal_grid, flag_grid}), 64'd0);
      check("reset_cursor", 64'(cursor_grid), 64'h001);
      check("reset_wl_den", 64'({wl, d_enable}), 64'd0);
      model_new_game();
      reset = 1'b1;
      n = 0;
      while (cs != S_GAME && n < 3) begin tick(1); n++; end
      check("start_cs", 64'(cs), 64'(S_GAME));
      check("start_bomb", 64'(bomb_grid), 64'h180);
      check("start_cursor", 64'(cursor_grid), 64'h001);
      tick(2);
      settle("start");

      // 2: right x3 saturates at column 2
      for (int k = 0; k < 3; k++) do_move(3);
      check("saturate_cursor", 64'(cursor_grid), 64'h004);

      // 3: reveal all safe cells -> win, then keys ignored
      for (int i = 0; i < 7; i++) begin
         goto_cell(i / W, i % W);
         do_reveal();
      end
      check("win_reveal", 64'(reveal_grid), 64'h07F);
      check("win_wl", 64'(wl), 64'(WL_WIN));
      check("win_cs", 64'(cs), 64'(S_WIN));
      do_move(1); do_reveal(); do_flag();
      check("win_frozen", 64'(dut_snap()), 64'({m_bomb, m_rev, m_flag, m_cursor()}));
      check("win_cs_hold", 64'(cs), 64'(S_WIN));

      // 4: flag blocks reveal, unflag, hit a mine -> lose
      do_restart();
      do_flag();
      check("flag_set", 64'(flag_grid), 64'h001);
      do_reveal();
      check("flagged_no_reveal", 64'(reveal_grid), 64'h000);
      do_flag();
      check("flag_clear", 64'(flag_grid), 64'h000);
      goto_cell(2, 1);
      do_reveal();
      check("lose_wl", 64'(wl), 64'(WL_LOSE));
      check("lose_cs", 64'(cs), 64'(S_LOSE));

      // 6: restart during S_SET_BOMB and during S_MOVE
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      tick(1);
      check("abort_place_in", 64'(cs), 64'(S_SET_BOMB));
      restart = 1'b1;
      tick(1);
      check_cleared("abort_place");
      model_new_game();
      restart = 1'b0;
      tick(4);
      settle("abort_place");
      do_move(1);
      udlr = 4'b0001;
      readkey = 1'b1;
      tick(2);
      check("abort_move_in", 64'(cs), 64'(S_MOVE));
      restart = 1'b1;
      readkey = 1'b0;
      udlr = 4'b0;
      tick(1);
      check_cleared("abort_move");
      model_new_game();
      restart = 1'b0;
      tick(4);
      settle("abort_move");

      // random play against the model
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      do_move($urandom_range(0, 3));
         else if (r < 8) do_reveal();
         else            do_flag();
         if (m_wl != WL_PLAY) begin
            check("rand_end_cs", 64'(cs), 64'((m_wl == WL_WIN) ? S_WIN : S_LOSE));
            do_restart();
         end
      end

      // 5: random placement on instance B
      for (int k = 0; k < 20; k++) begin
         restart_b = 1'b1;
         tick($urandom_range(1, 6));
         restart_b = 1'b0;
         n = 0;
         while (cs_b != S_GAME && n < 3000) begin tick(1); n++; end
         check("b_reach_game", 64'(cs_b), 64'(S_GAME));
         check("b_pulse", 64'(d_enable_b), 64'd1);
         check("b_popcount", 64'($countones(bomb_b)), 64'd2);
         check("b_other", 64'({wl_b, reveal_b, flag_b, cursor_b}), 64'h001);
         maps[k] = bomb_b;
         $display("random map %0d: bomb_grid=%03h", k, bomb_b);
         tick($urandom_range(0, 7));
      end
      differ = 1'b0;
      for (int k = 1; k < 20; k++) if (maps[k] != maps[0]) differ = 1'b1;
      check("b_maps_vary", 64'(differ), 64'd1);

      tick(3);
      check("final_pending", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
